debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-input pushbutton debouncer.
- Each of N channels has its own resources:
  - a 2-stage synchroniser;
  - a programmable stability counter, replacing the fixed "bounce < 2 clocks" assumption;
  - a registered debounced level;
  - one-cycle rise and fall strobes.
- Sits between board switches/buttons and control FSMs. All outputs are synchronous to clk.

Parameters:
- N, 4, number of independent channels (>=1).
- STABLE_CYCLES, 4, consecutive cycles the synchronised input must differ from the debounced level before the level changes (>=1).
- CNT_W, 3, stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES. Elaboration fails otherwise.
- INIT_LEVEL, 0, reset value of the debounced level and of both synchroniser stages, all channels (0 or 1).

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- b, input, N, raw bouncy inputs, asynchronous to clk.
- s, output, N, debounced, synchronised levels.
- rise, output, N, one-cycle strobe when s[i] goes 0->1.
- fall, output, N, one-cycle strobe when s[i] goes 1->0.

Behaviour:
- Reset (rst=1 at a rising edge) applies to all channels:
  - sync0[i] and sync1[i] are set to INIT_LEVEL;
  - s[i] is set to INIT_LEVEL;
  - cnt[i] is set to 0;
  - rise[i] and fall[i] are set to 0.
  - rst has priority over all other logic.
  - Reset mid-count discards the count; no strobe is issued.
- Synchroniser:
  - sync0[i] <= b[i];
  - sync1[i] <= sync0[i].
  - Only sync1 feeds the filter.
- Filter, per channel, evaluated every edge with rst=0:
  - If sync1[i] == s[i]: cnt[i] <= 0; s unchanged; strobes 0.
  - Else if cnt[i] == STABLE_CYCLES-1: s[i] <= sync1[i]; cnt[i] <= 0; rise[i] <= sync1[i]; fall[i] <= ~sync1[i].
  - Else: cnt[i] <= cnt[i]+1; strobes 0.
- Latency: b[i] changes, then holds for STABLE_CYCLES+2 rising edges. s[i] updates at the (STABLE_CYCLES+2)th edge after b[i] is first sampled. The strobe is asserted in the same cycle s changes.
- Rejection: any reversion of sync1 to s before the count completes clears cnt. The pulse is ignored and no strobe is issued. A glitch shorter than STABLE_CYCLES cycles (as seen at sync1) is never propagated.
- Strobe rules:
  - rise and fall are high for exactly 1 cycle.
  - Never both high on one channel.
  - The minimum spacing between successive strobes on one channel is STABLE_CYCLES cycles.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro: DEBOUNCE_MULTI_TOGGLE_EN.
- Defined:
  - Adds output port tog (N bits), reset to 0.
  - tog[i] inverts on every cycle where rise[i]=1 (push-on/push-off switch).
  - Changes in the same cycle as the rise strobe is visible. Unaffected by fall.
- Undefined: port tog and its registers do not exist. All other behaviour is identical.

Test Plan:
- Test parameters: N=4, STABLE_CYCLES=4, INIT_LEVEL=0.
- Reset: assert rst 2 cycles with b=4'b1111. Required after release: s=0, rise=0, fall=0, and tog=0 if enabled.
- Clean press: b[0] 0->1 just after edge E0 and held. Required:
  - s[0]=1 visible after edge E0+6;
  - rise[0]=1 for exactly that one cycle;
  - fall=0 throughout;
  - other channels unchanged.
- Bounce rejection: b[1] high for 3 cycles then low. Required: s[1] stays 0; no strobes. Then b[1] high 4+ cycles: s[1] rises after 6 edges.
- Release and simultaneity: b[2] and b[3] both 1->0 in the same cycle from a debounced high. Required: s[2] and s[3] fall on the same edge; fall[2] and fall[3] strobe together for 1 cycle.
- Reset mid-operation: b[0] rises, rst asserted at the 4th edge (count in progress), b held high. Required:
  - no rise strobe while rst is active;
  - after release, s[0] goes to 1 only after a fresh 6-edge delay.
- Toggle (macro defined): press/release b[0] three times, each level held 8 cycles. Required:
  - tog[0] sequence 1,0,1, changing on each rise[0] cycle;
  - tog[1..3]=0.

Source files
------------

// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel switch/pushbutton debouncer. Every channel is independent
// and has its own two-flop synchroniser, a programmable stability counter,
// a registered debounced level and one-cycle rise/fall strobes. A channel's
// level only follows its input after the synchronised input has disagreed
// with the current level for STABLE_CYCLES consecutive clocks. Any earlier
// return to the current level discards the partial count.
//
// Parameters:
//   N             number of channels (>= 1)
//   STABLE_CYCLES consecutive disagreeing cycles needed to change level (>= 1)
//   CNT_W         stability counter width, 2**CNT_W must exceed STABLE_CYCLES
//   INIT_LEVEL    reset value of the synchronisers and debounced level (0/1)
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset, overrides all other logic
//   b      in   N  raw bouncy inputs, asynchronous to clk
//   s      out  N  debounced, synchronised levels
//   rise   out  N  one-cycle strobe when s[i] goes 0->1
//   fall   out  N  one-cycle strobe when s[i] goes 1->0
//   tog    out  N  push-on/push-off state, inverts on each rise strobe
//                  (present only when DEBOUNCE_MULTI_TOGGLE_EN is defined)
//
// Optional feature macro: DEBOUNCE_MULTI_TOGGLE_EN
// ---------------------------------------------------------------------------
module debounce_multi #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3,
    parameter int INIT_LEVEL    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
    ,
    output logic [N-1:0] tog
`endif
);

    // Reject parameter sets that would make the counter wrap or the block
    // meaningless, rather than silently building something broken.
    generate
        if ((2 ** CNT_W) <= STABLE_CYCLES) begin : g_bad_cnt_w
            $error("debounce_multi: 2**CNT_W must exceed STABLE_CYCLES");
        end
        if (N < 1) begin : g_bad_n
            $error("debounce_multi: N must be at least 1");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("debounce_multi: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic             INIT_BIT = (INIT_LEVEL != 0);

    logic [N-1:0]     sync0;
    logic [N-1:0]     sync1;
    logic [CNT_W-1:0] cnt       [N];
    logic [CNT_W-1:0] cnt_next  [N];
    logic [N-1:0]     s_next;
    logic [N-1:0]     rise_next;
    logic [N-1:0]     fall_next;

    // Stability filter. A channel whose synchronised input agrees with its
    // debounced level is idle and keeps its counter cleared, so any bounce
    // back to the old level restarts the qualification from zero. The level
    // flips on the cycle the counter would reach STABLE_CYCLES, which keeps
    // the counter inside 0..STABLE_CYCLES-1 and lets the strobes be derived
    // directly from the new level.
    always_comb begin
        s_next    = s;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (sync1[i] == s[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                s_next[i]    = sync1[i];
                rise_next[i] = sync1[i];
                fall_next[i] = ~sync1[i];
                cnt_next[i]  = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counters, debounced levels and strobes. Reset puts the
    // synchroniser at the same level as s so that a channel leaving reset
    // never sees a spurious disagreement from stale flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= {N{INIT_BIT}};
            sync1 <= {N{INIT_BIT}};
            s     <= {N{INIT_BIT}};
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync0 <= b;
            sync1 <= sync0;
            s     <= s_next;
            rise  <= rise_next;
            fall  <= fall_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef DEBOUNCE_MULTI_TOGGLE_EN
    // Push-on/push-off state. Using the next-cycle rise value makes tog
    // change on the same edge that raises the rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog <= '0;
        end else begin
            tog <= tog ^ rise_next;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//
// Self-checking bench for debounce_multi (N=4, STABLE_CYCLES=4, INIT_LEVEL=0).
// Directed scenarios check the documented latencies with constant
// expectations; a randomised phase compares every cycle against a reference
// model that keeps, per channel, a sliding window of the most recent filter
// samples and changes the level once the whole window disagrees with it.
// Define DEBOUNCE_MULTI_TOGGLE_EN to also exercise the tog output.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int N = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] b   = '1;
    logic [N-1:0] s;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
    logic [N-1:0] tog;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [N-1:0] m_d1;
    bit [N-1:0] m_d2;
    bit [N-1:0] m_s;
    bit [N-1:0] m_rise;
    bit [N-1:0] m_fall;
    bit [N-1:0] m_tog;
    bit         m_win [N][$];

    debounce_multi #(
        .N(N),
        .STABLE_CYCLES(S),
        .CNT_W(3),
        .INIT_LEVEL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .b(b),
        .s(s),
        .rise(rise),
        .fall(fall)
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
        ,
        .tog(tog)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "[TB] timeout");
    end

    // Reference model, applied once per rising edge using the inputs that
    // were stable before the edge. The input reaches the filter two edges
    // after it is sampled; the level changes when the last S filter samples
    // since the previous change all disagree with the current level.
    task automatic model_edge();
        bit seen;
        bit all_diff;
        if (rst) begin
            m_d1   = '0;
            m_d2   = '0;
            m_s    = '0;
            m_rise = '0;
            m_fall = '0;
            m_tog  = '0;
            for (int i = 0; i < N; i++) m_win[i].delete();
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                seen    = m_d2[i];
                m_d2[i] = m_d1[i];
                m_d1[i] = b[i];
                m_win[i].push_back(seen);
                if (m_win[i].size() > S) void'(m_win[i].pop_front());
                all_diff = (m_win[i].size() == S);
                for (int j = 0; j < m_win[i].size(); j++) begin
                    if (m_win[i][j] == m_s[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_s[i]    = seen;
                    m_rise[i] = seen;
                    m_fall[i] = !seen;
                    m_win[i].delete();
                end
            end
            m_tog = m_tog ^ m_rise;
        end
    endtask

    // Advance one rising edge, update the model, then move 1 ns past the
    // edge where outputs are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        b   = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (s !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_s: got %b want 0000", s);
        end
        checks++;
        if (rise !== 4'b0000 || fall !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got rise=%b fall=%b want 0000/0000", rise, fall);
        end
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
        checks++;
        if (tog !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_tog: got %b want 0000", tog);
        end
`endif
        tick();
        checks++;
        if (s !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_release_s: got %b want 0000", s);
        end
        b = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_clean_press();
        $display("[TB] test_clean_press");
        b[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (s[0] !== (k >= 6)) begin
                errors++;
                $display("[TB] FAIL press_s0 edge %0d: got %b want %b", k, s[0], (k >= 6));
            end
            checks++;
            if (rise[0] !== (k == 6)) begin
                errors++;
                $display("[TB] FAIL press_rise0 edge %0d: got %b want %b", k, rise[0], (k == 6));
            end
            checks++;
            if (fall !== 4'b0000 || s[3:1] !== 3'b000 || rise[3:1] !== 3'b000) begin
                errors++;
                $display("[TB] FAIL press_others edge %0d: got s=%b rise=%b fall=%b want s[3:1]=0 rise[3:1]=0 fall=0",
                         k, s, rise, fall);
            end
        end
    endtask

    task automatic test_bounce_rejection();
        $display("[TB] test_bounce_rejection");
        b[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) b[1] = 1'b0;
            checks++;
            if (s[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce_reject edge %0d: got s1=%b rise1=%b fall1=%b want 0/0/0",
                         k, s[1], rise[1], fall[1]);
            end
        end
        b[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (s[1] !== (k >= 6) || rise[1] !== (k == 6)) begin
                errors++;
                $display("[TB] FAIL bounce_accept edge %0d: got s1=%b rise1=%b want %b/%b",
                         k, s[1], rise[1], (k >= 6), (k == 6));
            end
        end
    endtask

    task automatic test_simultaneous_release();
        $display("[TB] test_simultaneous_release");
        b[3:2] = 2'b11;
        repeat (8) tick();
        checks++;
        if (s !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL release_setup: got %b want 1111", s);
        end
        b[3:2] = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (s[3:2] !== ((k >= 6) ? 2'b00 : 2'b11) || fall[3:2] !== ((k == 6) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL release_pair edge %0d: got s=%b fall=%b", k, s, fall);
            end
            checks++;
            if (rise !== 4'b0000 || fall[1:0] !== 2'b00 || s[1:0] !== 2'b11) begin
                errors++;
                $display("[TB] FAIL release_others edge %0d: got s=%b rise=%b fall=%b want s[1:0]=11 rise=0 fall[1:0]=0",
                         k, s, rise, fall);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        $display("[TB] test_reset_mid_count");
        b = 4'b0000;
        repeat (8) tick();
        b[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (rise !== 4'b0000 || s !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL mid_reset_active cycle %0d: got s=%b rise=%b want 0000/0000", k, s, rise);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (s[0] !== (k >= 6) || rise[0] !== (k == 6)) begin
                errors++;
                $display("[TB] FAIL mid_reset_fresh edge %0d: got s0=%b rise0=%b want %b/%b",
                         k, s[0], rise[0], (k >= 6), (k == 6));
            end
        end
    endtask

`ifdef DEBOUNCE_MULTI_TOGGLE_EN
    task automatic test_toggle();
        bit before;
        bit after;
        $display("[TB] test_toggle");
        rst = 1'b1;
        b   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            before = (p == 1);
            after  = (p != 1);
            b[0] = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                tick();
                checks++;
                if (tog[0] !== ((k >= 6) ? after : before) || rise[0] !== (k == 6)) begin
                    errors++;
                    $display("[TB] FAIL toggle_press %0d edge %0d: got tog0=%b rise0=%b want %b/%b",
                             p, k, tog[0], rise[0], ((k >= 6) ? after : before), (k == 6));
                end
            end
            b[0] = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                checks++;
                if (tog[0] !== after || tog[3:1] !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL toggle_release %0d edge %0d: got tog=%b want tog0=%b tog[3:1]=000",
                             p, k, tog, after);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        int hold [N];
        $display("[TB] test_random");
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    b[i]    = $urandom_range(0, 1);
                    hold[i] = $urandom_range(1, 8);
                end else begin
                    hold[i]--;
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if (s !== m_s || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got s=%b rise=%b fall=%b want s=%b rise=%b fall=%b",
                         c, s, rise, fall, m_s, m_rise, m_fall);
            end
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
            checks++;
            if (tog !== m_tog) begin
                errors++;
                $display("[TB] FAIL random_tog cycle %0d: got %b want %b", c, tog, m_tog);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_rejection();
        test_simultaneous_release();
        test_reset_mid_count();
`ifdef DEBOUNCE_MULTI_TOGGLE_EN
        test_toggle();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
